// File: rtl/seg7_scan_driver.sv
// Six-digit multiplexed 7-segment scan driver with anti-ghost blanking,
// leading-zero suppression on the hours-tens digit and a blinking colon.
module seg7_scan_driver #(
    parameter int unsigned DIGIT_TICKS = 100_000,
    parameter int unsigned BLANK_TICKS = 1_000,
    parameter int unsigned BLINK_TICKS = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       lz_blank,
    input  logic [3:0] s1,
    input  logic [3:0] s2,
    input  logic [3:0] m1,
    input  logic [3:0] m2,
    input  logic [3:0] h1,
    input  logic [3:0] h2,
    output logic [5:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame_done
);

    localparam int unsigned MAXT = (DIGIT_TICKS > BLANK_TICKS) ? DIGIT_TICKS : BLANK_TICKS;
    localparam int unsigned TW   = ($clog2(MAXT) > 0) ? $clog2(MAXT) : 1;
    localparam int unsigned BW   = ($clog2(BLINK_TICKS) > 0) ? $clog2(BLINK_TICKS) : 1;

    localparam logic [TW-1:0] DIGIT_LAST = TW'(DIGIT_TICKS - 1);
    localparam logic [TW-1:0] BLANK_LAST = TW'(BLANK_TICKS - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);

    typedef enum logic {
        BLANK,
        DRIVE
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    idx_q, idx_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [BW-1:0] blink_q, blink_d;
    logic          phase_q, phase_d;
    logic [5:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;
    logic          fd_q, fd_d;

    logic [3:0]    digit_sel;
    logic [6:0]    slot_seg;

    function automatic logic [6:0] decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h3F;
        endcase
        return s;
    endfunction

    always_comb begin
        digit_sel = '0;
        case (idx_q)
            3'd0:    digit_sel = s1;
            3'd1:    digit_sel = s2;
            3'd2:    digit_sel = m1;
            3'd3:    digit_sel = m2;
            3'd4:    digit_sel = h1;
            3'd5:    digit_sel = h2;
            default: digit_sel = '0;
        endcase
        slot_seg = decode(digit_sel);
        if (idx_q == 3'd5 && lz_blank && h2 == 4'd0) begin
            slot_seg = 7'h7F;
        end
    end

    // Blink counter is independent of en so the colon phase never slips.
    always_comb begin
        blink_d = blink_q + BW'(1);
        phase_d = phase_q;
        if (blink_q == BLINK_LAST) begin
            blink_d = '0;
            phase_d = ~phase_q;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        tick_d  = tick_q + TW'(1);
        seg_d   = seg_q;
        fd_d    = 1'b0;

        if (!en) begin
            state_d = BLANK;
            idx_d   = '0;
            tick_d  = '0;
        end else begin
            case (state_q)
                BLANK: begin
                    if (tick_q == BLANK_LAST) begin
                        state_d = DRIVE;
                        tick_d  = '0;
                        seg_d   = slot_seg;
                    end
                end
                DRIVE: begin
                    if (tick_q == DIGIT_LAST) begin
                        state_d = BLANK;
                        tick_d  = '0;
                        idx_d   = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
                        fd_d    = (idx_q == 3'd5);
                    end
                end
                default: begin
                    state_d = BLANK;
                    tick_d  = '0;
                end
            endcase
        end

        // Outputs are derived from next-state values so the registered
        // outputs line up with the registered state.
        if (state_d == DRIVE) begin
            an_d = ~(6'b000001 << idx_d);
        end else begin
            an_d  = '1;
            seg_d = 7'h7F;
        end
        dp_d = ~((state_d == DRIVE) && (idx_d == 3'd2 || idx_d == 3'd4) && phase_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= BLANK;
            idx_q   <= '0;
            tick_q  <= '0;
            blink_q <= '0;
            phase_q <= 1'b1;
            an_q    <= '1;
            seg_q   <= 7'h7F;
            dp_q    <= 1'b1;
            fd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            tick_q  <= tick_d;
            blink_q <= blink_d;
            phase_q <= phase_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            fd_q    <= fd_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with DIGIT_TICKS=4, BLANK_TICKS=2,
// BLINK_TICKS=16; expected outputs come from a cycle-indexed scan model.
module tb_seg7_scan_driver;

    logic       clk;
    logic       rst;
    logic       en;
    logic       lz_blank;
    logic [3:0] s1, s2, m1, m2, h1, h2;
    logic [5:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame_done;

    int ncmp;
    int nfail;
    int cyc;
    int base;

    // Digit values the display is expected to show, idx0 = s1 .. idx5 = h2.
    logic [3:0] mdl [6];
    logic       lz_m;

    logic [6:0] segtab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};

    seg7_scan_driver #(
        .DIGIT_TICKS(4),
        .BLANK_TICKS(2),
        .BLINK_TICKS(16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .lz_blank  (lz_blank),
        .s1        (s1),
        .s2        (s2),
        .m1        (m1),
        .m2        (m2),
        .h1        (h1),
        .h2        (h2),
        .an        (an),
        .seg       (seg),
        .dp        (dp),
        .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [6:0] got, input logic [6:0] exp);
        ncmp++;
        assert (got === exp) else begin
            nfail++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic set_digits(input logic [3:0] vh2, input logic [3:0] vh1, input logic [3:0] vm2,
                              input logic [3:0] vm1, input logic [3:0] vs2, input logic [3:0] vs1);
        h2 = vh2; h1 = vh1; m2 = vm2; m1 = vm1; s2 = vs2; s1 = vs1;
        mdl[5] = vh2; mdl[4] = vh1; mdl[3] = vm2; mdl[2] = vm1; mdl[1] = vs2; mdl[0] = vs1;
    endtask

    task automatic chk_off(input string tag);
        chk({tag, "_an"},  {1'b0, an}, 7'h3F);
        chk({tag, "_seg"}, seg, 7'h7F);
        chk({tag, "_dp"},  {6'd0, dp}, 7'd1);
        chk({tag, "_fd"},  {6'd0, frame_done}, 7'd0);
    endtask

    task automatic check_scan();
        int p, k, r;
        logic       drive;
        logic [5:0] ea;
        logic [6:0] es;
        logic       ed, ef;
        p     = (cyc - base) % 36;
        k     = p / 6;
        r     = p % 6;
        drive = (r >= 2);
        ea    = 6'h3F;
        es    = 7'h7F;
        if (drive) begin
            ea = 6'b000001 << k;
            ea = ~ea;
            es = segtab[mdl[k]];
            if (k == 5 && lz_m && mdl[5] == 4'd0) es = 7'h7F;
        end
        ed = ~(drive && (k == 2 || k == 4) && (((cyc / 16) % 2) == 0));
        ef = ((cyc - base) > 0) && (p == 0);
        chk("scan_an",  {1'b0, an}, {1'b0, ea});
        chk("scan_seg", seg, es);
        chk("scan_dp",  {6'd0, dp}, {6'd0, ed});
        chk("scan_fd",  {6'd0, frame_done}, {6'd0, ef});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            check_scan();
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk_off("reset");
        rst  = 1'b0;
        cyc  = 0;
        base = 0;
        check_scan();
    endtask

    initial begin
        ncmp     = 0;
        nfail    = 0;
        cyc      = 0;
        base     = 0;
        rst      = 1'b1;
        en       = 1'b1;
        lz_blank = 1'b0;
        lz_m     = 1'b0;
        set_digits(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
        repeat (3) @(posedge clk);
        #1;

        // Basic scan: two full frames, colon windows, frame_done at 36 and 72.
        do_reset();
        run(72);

        // Leading-zero blanking with a dash on m1, then blanking disabled.
        lz_blank = 1'b1;
        lz_m     = 1'b1;
        set_digits(4'd0, 4'd2, 4'd3, 4'hC, 4'd5, 4'd6);
        do_reset();
        run(36);
        lz_blank = 1'b0;
        lz_m     = 1'b0;
        run(36);

        // s1 changed mid-DRIVE of idx 0 is shown only from the next idx-0 slot.
        set_digits(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
        do_reset();
        run(3);
        s1 = 4'd9;
        run(33);
        mdl[0] = 4'd9;
        run(6);

        // en dropped mid-DRIVE of idx 3, then restored.
        do_reset();
        run(21);
        en = 1'b0;
        step();
        chk_off("en_off1");
        step();
        chk_off("en_off2");
        en   = 1'b1;
        base = cyc;
        check_scan();
        run(40);

        // rst mid-frame (during idx 0 drive) restarts cleanly.
        do_reset();
        run(12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
